// File: rtl/reg_wr_arb.sv
// Two-requester register-file write arbiter with a power-up clear sequence.
// Round-robin grant between A and B; granted writes are issued one cycle later.
module reg_wr_arb #(
  parameter int AW = 3,
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          a_req,
  input  logic [AW-1:0] a_addr,
  input  logic [DW-1:0] a_data,
  output logic          a_gnt,
  input  logic          b_req,
  input  logic [AW-1:0] b_addr,
  input  logic [DW-1:0] b_data,
  output logic          b_gnt,
  output logic          rf_wr_en,
  output logic [AW-1:0] rf_wr_addr,
  output logic [DW-1:0] rf_dat_in,
  output logic          init_busy,
  output logic [7:0]    conflict_cnt
);

  // state | meaning
  // INIT  | clearing every register to zero, one address per cycle; no grants
  // RUN   | arbitrating A/B write requests
  typedef enum logic {INIT, RUN} state_t;

  localparam logic [AW:0] DEPTH = {1'b1, {AW{1'b0}}};

  state_t      state;
  logic [AW:0] init_cnt;
  logic        prio_b;

  assign init_busy = (state == INIT);

  // prio_b set means A was granted most recently, so B wins a tie
  always_comb begin
    a_gnt = 1'b0;
    b_gnt = 1'b0;
    if (state == RUN) begin
      if (a_req && (!b_req || !prio_b)) a_gnt = 1'b1;
      else if (b_req)                   b_gnt = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= INIT;
      init_cnt     <= '0;
      prio_b       <= 1'b0;
      rf_wr_en     <= 1'b0;
      rf_wr_addr   <= '0;
      rf_dat_in    <= '0;
      conflict_cnt <= '0;
    end else if (state == INIT) begin
      // the extra count step keeps INIT (and init_busy) up while the last clear write is visible
      if (init_cnt == DEPTH) begin
        state    <= RUN;
        rf_wr_en <= 1'b0;
      end else begin
        rf_wr_en   <= 1'b1;
        rf_wr_addr <= init_cnt[AW-1:0];
        rf_dat_in  <= '0;
        init_cnt   <= init_cnt + 1'b1;
      end
    end else begin
      rf_wr_en <= a_gnt | b_gnt;
      if (a_gnt) begin
        rf_wr_addr <= a_addr;
        rf_dat_in  <= a_data;
        prio_b     <= 1'b1;
      end else if (b_gnt) begin
        rf_wr_addr <= b_addr;
        rf_dat_in  <= b_data;
        prio_b     <= 1'b0;
      end
      if (a_req && b_req && conflict_cnt != 8'hFF)
        conflict_cnt <= conflict_cnt + 8'd1;
    end
  end

endmodule

// File: tb/tb_reg_wr_arb.sv
// Directed bench for reg_wr_arb: vector table for RUN arbitration plus
// hand-written sequences for clear, same-address, saturation and reset cases.
module tb_reg_wr_arb;
  localparam int AW = 3;
  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          a_req = 1'b0, b_req = 1'b0;
  logic [AW-1:0] a_addr = '0, b_addr = '0;
  logic [DW-1:0] a_data = '0, b_data = '0;
  logic          a_gnt, b_gnt, rf_wr_en, init_busy;
  logic [AW-1:0] rf_wr_addr;
  logic [DW-1:0] rf_dat_in;
  logic [7:0]    conflict_cnt;

  int checks = 0;
  int errors = 0;

  reg_wr_arb #(.AW(AW), .DW(DW)) dut (
    .clk(clk), .rst_n(rst_n),
    .a_req(a_req), .a_addr(a_addr), .a_data(a_data), .a_gnt(a_gnt),
    .b_req(b_req), .b_addr(b_addr), .b_data(b_data), .b_gnt(b_gnt),
    .rf_wr_en(rf_wr_en), .rf_wr_addr(rf_wr_addr), .rf_dat_in(rf_dat_in),
    .init_busy(init_busy), .conflict_cnt(conflict_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          ar;
    logic [AW-1:0] aa;
    logic [DW-1:0] ad;
    logic          br;
    logic [AW-1:0] ba;
    logic [DW-1:0] bd;
    logic          e_ag;
    logic          e_bg;
    logic          e_wen;
    logic [AW-1:0] e_waddr;
    logic [DW-1:0] e_wdat;
    logic [7:0]    e_cnt;
  } vec_t;

  vec_t tbl[13];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, " a_gnt"}, 32'(a_gnt), 32'd0);
    chk({tag, " b_gnt"}, 32'(b_gnt), 32'd0);
    chk({tag, " rf_wr_en"}, 32'(rf_wr_en), 32'd0);
    chk({tag, " rf_wr_addr"}, 32'(rf_wr_addr), 32'd0);
    chk({tag, " rf_dat_in"}, 32'(rf_dat_in), 32'd0);
    chk({tag, " init_busy"}, 32'(init_busy), 32'd1);
    chk({tag, " conflict_cnt"}, 32'(conflict_cnt), 32'd0);
  endtask

  // Called at a negedge just after rst_n release; ends at the first RUN cycle.
  task automatic init_seq(input string tag);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk({tag, " init wr_en"}, 32'(rf_wr_en), 32'd1);
      chk({tag, " init addr"}, 32'(rf_wr_addr), 32'(i));
      chk({tag, " init data"}, 32'(rf_dat_in), 32'd0);
      chk({tag, " init busy"}, 32'(init_busy), 32'd1);
      chk({tag, " init gnt"}, 32'({a_gnt, b_gnt}), 32'd0);
      chk({tag, " init cnt"}, 32'(conflict_cnt), 32'd0);
    end
    @(negedge clk);
    chk({tag, " run busy"}, 32'(init_busy), 32'd0);
    chk({tag, " run wr_en"}, 32'(rf_wr_en), 32'd0);
  endtask

  initial begin
    tbl[0]  = '{1'b1, 3'd1, 8'h11, 1'b1, 3'd2, 8'h22, 1'b1, 1'b0, 1'b0, 3'd0, 8'h00, 8'd0};
    tbl[1]  = '{1'b1, 3'd1, 8'h11, 1'b1, 3'd2, 8'h22, 1'b0, 1'b1, 1'b1, 3'd1, 8'h11, 8'd1};
    tbl[2]  = '{1'b1, 3'd1, 8'h11, 1'b1, 3'd2, 8'h22, 1'b1, 1'b0, 1'b1, 3'd2, 8'h22, 8'd2};
    tbl[3]  = '{1'b1, 3'd1, 8'h11, 1'b1, 3'd2, 8'h22, 1'b0, 1'b1, 1'b1, 3'd1, 8'h11, 8'd3};
    tbl[4]  = '{1'b1, 3'd3, 8'h5A, 1'b0, 3'd0, 8'h00, 1'b1, 1'b0, 1'b1, 3'd2, 8'h22, 8'd4};
    tbl[5]  = '{1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 8'h00, 1'b0, 1'b0, 1'b1, 3'd3, 8'h5A, 8'd4};
    tbl[6]  = '{1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 8'h00, 1'b0, 1'b0, 1'b0, 3'd0, 8'h00, 8'd4};
    tbl[7]  = '{1'b0, 3'd0, 8'h00, 1'b1, 3'd6, 8'h66, 1'b0, 1'b1, 1'b0, 3'd0, 8'h00, 8'd4};
    tbl[8]  = '{1'b1, 3'd4, 8'h44, 1'b1, 3'd7, 8'h77, 1'b1, 1'b0, 1'b1, 3'd6, 8'h66, 8'd4};
    tbl[9]  = '{1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 8'h00, 1'b0, 1'b0, 1'b1, 3'd4, 8'h44, 8'd5};
    tbl[10] = '{1'b0, 3'd0, 8'h00, 1'b1, 3'd0, 8'h0F, 1'b0, 1'b1, 1'b0, 3'd0, 8'h00, 8'd5};
    tbl[11] = '{1'b0, 3'd0, 8'h00, 1'b1, 3'd1, 8'h10, 1'b0, 1'b1, 1'b1, 3'd0, 8'h0F, 8'd5};
    tbl[12] = '{1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 8'h00, 1'b0, 1'b0, 1'b1, 3'd1, 8'h10, 8'd5};

    // Reset values, with requests active to show grants stay low
    a_req = 1'b1; b_req = 1'b1;
    #12;
    chk_reset_vals("por");
    a_req = 1'b0; b_req = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    init_seq("clr");

    // Table: inputs applied mid-cycle at negedge, checked 1 ns later
    for (int i = 0; i < 13; i++) begin
      a_req = tbl[i].ar; a_addr = tbl[i].aa; a_data = tbl[i].ad;
      b_req = tbl[i].br; b_addr = tbl[i].ba; b_data = tbl[i].bd;
      #1;
      chk($sformatf("row%0d a_gnt", i), 32'(a_gnt), 32'(tbl[i].e_ag));
      chk($sformatf("row%0d b_gnt", i), 32'(b_gnt), 32'(tbl[i].e_bg));
      chk($sformatf("row%0d wr_en", i), 32'(rf_wr_en), 32'(tbl[i].e_wen));
      if (tbl[i].e_wen) begin
        chk($sformatf("row%0d wr_addr", i), 32'(rf_wr_addr), 32'(tbl[i].e_waddr));
        chk($sformatf("row%0d wr_dat", i), 32'(rf_dat_in), 32'(tbl[i].e_wdat));
      end
      chk($sformatf("row%0d cnt", i), 32'(conflict_cnt), 32'(tbl[i].e_cnt));
      @(negedge clk);
    end
    a_req = 1'b0; b_req = 1'b0;

    // Same address from both, requested during INIT
    rst_n = 1'b0;
    a_req = 1'b1; a_addr = 3'd5; a_data = 8'hAA;
    b_req = 1'b1; b_addr = 3'd5; b_data = 8'hBB;
    @(negedge clk); rst_n = 1'b1;
    init_seq("same");
    #1;
    chk("same gnt c0", 32'({a_gnt, b_gnt}), 32'b10);
    chk("same cnt c0", 32'(conflict_cnt), 32'd0);
    @(negedge clk); a_req = 1'b0; #1;
    chk("same gnt c1", 32'({a_gnt, b_gnt}), 32'b01);
    chk("same wr c1", 32'({rf_wr_en, rf_wr_addr, rf_dat_in}), 32'({1'b1, 3'd5, 8'hAA}));
    chk("same cnt c1", 32'(conflict_cnt), 32'd1);
    @(negedge clk); b_req = 1'b0; #1;
    chk("same gnt c2", 32'({a_gnt, b_gnt}), 32'b00);
    chk("same wr c2", 32'({rf_wr_en, rf_wr_addr, rf_dat_in}), 32'({1'b1, 3'd5, 8'hBB}));
    @(negedge clk);
    chk("same wr c3", 32'(rf_wr_en), 32'd0);

    // Saturation: count starts at 1 here, 300 more contended cycles
    a_req = 1'b1; a_addr = 3'd2; a_data = 8'h01;
    b_req = 1'b1; b_addr = 3'd3; b_data = 8'h02;
    repeat (300) @(negedge clk);
    chk("sat cnt", 32'(conflict_cnt), 32'd255);
    chk("sat wr_en", 32'(rf_wr_en), 32'd1);

    // Reset mid-RUN with a registered write pending
    rst_n = 1'b0; #1;
    chk_reset_vals("rst_run");
    a_req = 1'b0; b_req = 1'b0;
    @(negedge clk); rst_n = 1'b1;

    // Reset pulsed during INIT at address 4
    begin
      bit found = 1'b0;
      for (int i = 0; i < 20 && !found; i++) begin
        @(negedge clk);
        if (rf_wr_en && rf_wr_addr == 3'd4) found = 1'b1;
      end
      chk("wait addr4", 32'(found), 32'd1);
    end
    rst_n = 1'b0; #1;
    chk_reset_vals("rst_init");
    @(negedge clk); rst_n = 1'b1;
    init_seq("restart");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
